// File: rtl/sig_state_detector_pkg.sv
// Shared state codes and the per-clock classifier for the signal state detector.
// Encoding matches the legacy clock-state codes so existing comparators still apply.
package sig_state_detector_pkg;

    localparam int unsigned SIG_STATE_W = 3;

    typedef enum logic [SIG_STATE_W-1:0] {
        SIG_STATE_LOW       = 3'd0,
        SIG_STATE_HIGH      = 3'd1,
        SIG_STATE_RISE      = 3'd2,
        SIG_STATE_FALL      = 3'd3,
        SIG_STATE_UNDEFINED = 3'd4
    } sig_state_e;

    // Edges are only reported once the channel was already valid a cycle earlier,
    // so the acquisition step itself can never look like an edge.
    function automatic sig_state_e sig_classify(
        input logic valid,
        input logic valid_d,
        input logic filt,
        input logic filt_d
    );
        sig_state_e res;
        res = SIG_STATE_UNDEFINED;
        if (valid) begin
            if (valid_d && filt && !filt_d) begin
                res = SIG_STATE_RISE;
            end else if (valid_d && !filt && filt_d) begin
                res = SIG_STATE_FALL;
            end else if (filt) begin
                res = SIG_STATE_HIGH;
            end else begin
                res = SIG_STATE_LOW;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sig_state_chan.sv
// One monitored channel: 2-FF synchroniser, glitch filter, edge classifier,
// rise-to-rise period counter and stall flag.
module sig_state_chan
    import sig_state_detector_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int PERIOD_W   = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                sig_i,
    output sig_state_e          state_o,
    output logic                rise_o,
    output logic                fall_o,
    output logic [PERIOD_W-1:0] period_o,
    output logic                period_vld_o,
    output logic                stall_o
);

    localparam int FCNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [FCNT_W-1:0]   FCNT_LAST = FCNT_W'(FILTER_LEN - 1);
    localparam logic [PERIOD_W-1:0] PER_MAX   = '1;
    localparam logic [PERIOD_W-1:0] PER_PRE   = PER_MAX - PERIOD_W'(1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_sync_prev;
    logic [FCNT_W-1:0] r_fcnt;
    logic              r_valid;
    logic              r_valid_d;
    logic              r_filt;
    logic              r_filt_d;

    sig_state_e          r_state;
    logic                r_rise;
    logic                r_fall;
    logic [PERIOD_W-1:0] r_pcnt;
    logic [PERIOD_W-1:0] r_period;
    logic                r_period_vld;
    logic                r_armed;
    logic                r_stall;

    logic w_rise;
    logic w_fall;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync_prev <= 1'b0;
            r_fcnt      <= '0;
            r_valid     <= 1'b0;
            r_valid_d   <= 1'b0;
            r_filt      <= 1'b0;
            r_filt_d    <= 1'b0;
        end else begin
            r_sync1     <= sig_i;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
            r_valid_d   <= r_valid;
            r_filt_d    <= r_filt;
            if (!r_valid) begin
                // Acquisition: wait for FILTER_LEN consecutive unchanged samples.
                if (r_sync2 == r_sync_prev) begin
                    if (r_fcnt == FCNT_LAST) begin
                        r_valid <= 1'b1;
                        r_filt  <= r_sync2;
                        r_fcnt  <= '0;
                    end else begin
                        r_fcnt <= r_fcnt + FCNT_W'(1);
                    end
                end else begin
                    r_fcnt <= '0;
                end
            end else if (r_sync2 != r_filt) begin
                if (r_fcnt == FCNT_LAST) begin
                    r_filt <= ~r_filt;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + FCNT_W'(1);
                end
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    assign w_rise = r_valid & r_valid_d &  r_filt & ~r_filt_d;
    assign w_fall = r_valid & r_valid_d & ~r_filt &  r_filt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= SIG_STATE_UNDEFINED;
            r_rise       <= 1'b0;
            r_fall       <= 1'b0;
            r_pcnt       <= '0;
            r_period     <= '0;
            r_period_vld <= 1'b0;
            r_armed      <= 1'b0;
            r_stall      <= 1'b0;
        end else begin
            r_state      <= sig_classify(r_valid, r_valid_d, r_filt, r_filt_d);
            r_rise       <= w_rise;
            r_fall       <= w_fall;
            r_period_vld <= 1'b0;
            if (w_rise) begin
                // Counter restarts at 1 so it holds the RISE-to-RISE distance.
                r_pcnt  <= PERIOD_W'(1);
                r_armed <= 1'b1;
                r_stall <= 1'b0;
                if (r_armed) begin
                    r_period     <= r_pcnt;
                    r_period_vld <= 1'b1;
                end
            end else begin
                if (r_pcnt != PER_MAX) begin
                    r_pcnt <= r_pcnt + PERIOD_W'(1);
                end
                r_stall <= r_armed && (r_pcnt == PER_PRE || r_pcnt == PER_MAX);
            end
        end
    end

    assign state_o      = r_state;
    assign rise_o       = r_rise;
    assign fall_o       = r_fall;
    assign period_o     = r_period;
    assign period_vld_o = r_period_vld;
    assign stall_o      = r_stall;

endmodule

// File: rtl/sig_state_detector.sv
// N_CH independent signal state detectors packed onto flat output buses;
// channel c owns bit c of each 1-bit bus and the c-th slice of the wide ones.
module sig_state_detector
    import sig_state_detector_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int FILTER_LEN = 4,
    parameter int PERIOD_W   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_CH-1:0]            sig_i,
    output logic [SIG_STATE_W*N_CH-1:0] state_o,
    output logic [N_CH-1:0]            rise_o,
    output logic [N_CH-1:0]            fall_o,
    output logic [PERIOD_W*N_CH-1:0]   period_o,
    output logic [N_CH-1:0]            period_vld_o,
    output logic [N_CH-1:0]            stall_o
);

    for (genvar c = 0; c < N_CH; c++) begin : g_chan
        sig_state_e w_state;

        sig_state_chan #(
            .FILTER_LEN (FILTER_LEN),
            .PERIOD_W   (PERIOD_W)
        ) u_chan (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .sig_i        (sig_i[c]),
            .state_o      (w_state),
            .rise_o       (rise_o[c]),
            .fall_o       (fall_o[c]),
            .period_o     (period_o[c*PERIOD_W +: PERIOD_W]),
            .period_vld_o (period_vld_o[c]),
            .stall_o      (stall_o[c])
        );

        assign state_o[c*SIG_STATE_W +: SIG_STATE_W] = w_state;
    end

endmodule

// File: tb/tb_sig_state_detector.sv
// Directed bench for sig_state_detector: acquisition, edge latency, glitch
// suppression, period measurement, stall (PERIOD_W=4 instance) and async reset.
module tb_sig_state_detector;
    import sig_state_detector_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sig;
    logic [3:0]  sig4;

    logic [11:0] state;
    logic [3:0]  rise, fall, vld, stall;
    logic [63:0] period;

    logic [11:0] state4;
    logic [3:0]  rise4, fall4, vld4, stall4;
    logic [15:0] period4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sig_state_detector #(.N_CH(4), .FILTER_LEN(4), .PERIOD_W(16)) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .sig_i        (sig),
        .state_o      (state),
        .rise_o       (rise),
        .fall_o       (fall),
        .period_o     (period),
        .period_vld_o (vld),
        .stall_o      (stall)
    );

    sig_state_detector #(.N_CH(4), .FILTER_LEN(4), .PERIOD_W(4)) u_dut_p4 (
        .clk_i        (clk),
        .rst_i        (rst),
        .sig_i        (sig4),
        .state_o      (state4),
        .rise_o       (rise4),
        .fall_o       (fall4),
        .period_o     (period4),
        .period_vld_o (vld4),
        .stall_o      (stall4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pack4(input logic [2:0] s3, input logic [2:0] s2,
                                          input logic [2:0] s1, input logic [2:0] s0);
        return {s3, s2, s1, s0};
    endfunction

    function automatic logic [2:0] st(input logic [11:0] s, input int c);
        return s[3*c +: 3];
    endfunction

    // Channel-2 square wave, period 20: low for 10 cycles, then high for 10.
    task automatic square(input string tag, input int n_cyc, input bit armed_at_start,
                          output int n_r, output int n_v);
        n_r = 0;
        n_v = 0;
        for (int i = 0; i < n_cyc; i++) begin
            sig[2] = (((i / 10) % 2) == 1);
            @(negedge clk);
            if (vld[2]) n_v++;
            if (rise[2]) begin
                if (n_r == 0 && !armed_at_start) begin
                    chk({tag, "_first_rise_no_vld"}, 64'(vld[2]), 64'd0);
                end else begin
                    chk({tag, "_vld"}, 64'(vld[2]), 64'd1);
                    chk({tag, "_period"}, 64'(period[47:32]), 64'd20);
                end
                n_r++;
            end
        end
    endtask

    logic [11:0] all_undef;
    bit          bad;
    int          n_r, n_f, n_rs, n_fs, r_at, f_at, s_at, n_v;
    logic        first_vld;

    initial begin
        all_undef = pack4(SIG_STATE_UNDEFINED, SIG_STATE_UNDEFINED,
                          SIG_STATE_UNDEFINED, SIG_STATE_UNDEFINED);
        rst  = 1'b1;
        sig  = 4'b0101;
        sig4 = 4'b0000;
        repeat (3) @(negedge clk);
        chk("rst_state", 64'(state), 64'(all_undef));
        chk("rst_pulses", 64'({rise, fall, vld, stall}), 64'd0);
        chk("rst_period", period, 64'd0);
        chk("rst_state_p4", 64'(state4), 64'(all_undef));

        // Acquisition with 0101 held
        #2 rst = 1'b0;
        @(negedge clk);
        chk("acq_undef", 64'(state), 64'(all_undef));
        bad = 1'b0;
        repeat (15) begin
            @(negedge clk);
            bad |= (|rise) | (|fall) | (|rise4) | (|fall4) | (|vld);
        end
        chk("acq_no_edges", 64'(bad), 64'd0);
        chk("acq_state", 64'(state),
            64'(pack4(SIG_STATE_LOW, SIG_STATE_HIGH, SIG_STATE_LOW, SIG_STATE_HIGH)));
        chk("acq_state_p4", 64'(state4),
            64'(pack4(SIG_STATE_LOW, SIG_STATE_LOW, SIG_STATE_LOW, SIG_STATE_LOW)));

        // Ch0 clean step: RISE exactly after edge k+6
        sig[0] = 1'b0;
        repeat (12) @(negedge clk);
        chk("ch0_low", 64'(st(state, 0)), 64'(SIG_STATE_LOW));
        sig[0] = 1'b1;
        repeat (6) @(negedge clk);
        chk("ch0_pre_rise_state", 64'(st(state, 0)), 64'(SIG_STATE_LOW));
        chk("ch0_pre_rise_pulse", 64'(rise[0]), 64'd0);
        @(negedge clk);
        chk("ch0_rise_state", 64'(st(state, 0)), 64'(SIG_STATE_RISE));
        chk("ch0_rise_pulse", 64'(rise[0]), 64'd1);
        chk("ch0_arm_no_vld", 64'(vld[0]), 64'd0);
        @(negedge clk);
        chk("ch0_post_state", 64'(st(state, 0)), 64'(SIG_STATE_HIGH));
        chk("ch0_post_pulse", 64'(rise[0]), 64'd0);

        // Ch1 3-clock glitch is suppressed
        sig[1] = 1'b1;
        repeat (3) @(negedge clk);
        sig[1] = 1'b0;
        n_r = 0;
        bad = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rise[1]) n_r++;
            if (st(state, 1) != SIG_STATE_LOW) bad = 1'b1;
        end
        chk("glitch_no_rise", 64'(n_r), 64'd0);
        chk("glitch_stays_low", 64'(bad), 64'd0);

        // Ch1 4-clock pulse: RISE at +6, FALL at +10, one cycle each
        sig[1] = 1'b1;
        n_r = 0; n_f = 0; n_rs = 0; n_fs = 0; r_at = -1; f_at = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (rise[1]) begin n_r++; r_at = i; end
            if (fall[1]) begin n_f++; f_at = i; end
            if (st(state, 1) == SIG_STATE_RISE) n_rs++;
            if (st(state, 1) == SIG_STATE_FALL) n_fs++;
            if (i == 3) sig[1] = 1'b0;
        end
        chk("pulse_rise_cnt", 64'(n_r), 64'd1);
        chk("pulse_fall_cnt", 64'(n_f), 64'd1);
        chk("pulse_rise_at", 64'(r_at), 64'd6);
        chk("pulse_fall_at", 64'(f_at), 64'd10);
        chk("pulse_rise_state_len", 64'(n_rs), 64'd1);
        chk("pulse_fall_state_len", 64'(n_fs), 64'd1);

        // Ch2 square wave: first rise only arms, later rises report 20
        square("sq1", 100, 1'b0, n_r, n_v);
        chk("sq1_rises", 64'(n_r), 64'd5);
        chk("sq1_vlds", 64'(n_v), 64'd4);
        square("sq2", 45, 1'b1, n_r, n_v);
        chk("sq2_rises", 64'(n_r), 64'd2);
        chk("sq2_period_held", 64'(period[47:32]), 64'd20);

        // Asynchronous reset off the clock edge
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_state", 64'(state), 64'(all_undef));
        chk("arst_period", period, 64'd0);
        chk("arst_pulses", 64'({rise, fall, vld, stall, rise4, vld4, stall4}), 64'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("arst_reacq_undef", 64'(st(state, 2)), 64'(SIG_STATE_UNDEFINED));
        square("sq3", 100, 1'b0, n_r, n_v);
        chk("sq3_rises", 64'(n_r), 64'd5);
        chk("sq3_vlds", 64'(n_v), 64'd4);
        chk("sq3_state", 64'(state),
            64'(pack4(SIG_STATE_LOW, SIG_STATE_HIGH, SIG_STATE_LOW, SIG_STATE_HIGH)));

        // PERIOD_W=4 instance, ch3 held high: stall 14 clocks after the arming rise
        sig4[3] = 1'b1;
        r_at = -1; s_at = -1; first_vld = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rise4[3] && r_at < 0) begin r_at = i; first_vld = vld4[3]; end
            if (stall4[3] && s_at < 0) s_at = i;
        end
        chk("stall_rise_at", 64'(r_at), 64'd6);
        chk("stall_arm_no_vld", 64'(first_vld), 64'd0);
        chk("stall_set_at", 64'(s_at), 64'd20);
        chk("stall_held", 64'(stall4[3]), 64'd1);
        sig4[3] = 1'b0;
        repeat (10) @(negedge clk);
        chk("stall_fall_kept", 64'({stall4[3], fall4[3], st(state4, 3)}),
            64'({1'b1, 1'b0, SIG_STATE_LOW}));
        sig4[3] = 1'b1;
        repeat (6) @(negedge clk);
        chk("stall_pre_rise", 64'(stall4[3]), 64'd1);
        @(negedge clk);
        chk("stall_rise_pulse", 64'(rise4[3]), 64'd1);
        chk("stall_cleared", 64'(stall4[3]), 64'd0);
        chk("stall_vld", 64'(vld4[3]), 64'd1);
        chk("stall_period", 64'(period4[15:12]), 64'd15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
